// File: rtl/mfa_cfg_gen_mc_pkg.sv
// Shared types and constants for the MFA configuration generator: the forward token,
// the snoop FSM encoding and the attribute-word bit positions with their decoder.
package mfa_cfg_gen_mc_pkg;

  localparam int FTK_WIDTH               = 32;
  localparam int POSIT_ATTRIB_LENGTH_LSB = 0;
  localparam int POSIT_ATTRIB_SHARED     = FTK_WIDTH - 5;
  localparam int POSIT_ATTRIB_DENSE      = FTK_WIDTH - 4;
  localparam int POSIT_ATTRIB_NONZERO    = FTK_WIDTH - 3;

  // Wide enough for the largest restore block: 8 cfg + 3 fixed + 8 shared words.
  localparam int MFA_RD_CNT_W = 5;

  typedef struct packed {
    logic                 v;
    logic                 a;
    logic                 r;
    logic                 c;
    logic                 i;
    logic [FTK_WIDTH-1:0] d;
  } FTk_t;

  typedef enum logic [2:0] {
    IDLE,
    GET_R,
    GET_CFG,
    WAIT,
    READ_S,
    READ_L
  } fsm_cfg_gen_mc;

  typedef struct packed {
    logic shared;
    logic non_zero;
    logic dense;
  } attrib_flags_t;

  function automatic attrib_flags_t attribute_dec(input logic [FTK_WIDTH-1:0] attrib);
    attrib_flags_t f;
    f.shared   = attrib[POSIT_ATTRIB_SHARED];
    f.non_zero = attrib[POSIT_ATTRIB_NONZERO];
    f.dense    = attrib[POSIT_ATTRIB_DENSE];
    return f;
  endfunction

endpackage

// File: rtl/mfa_cfg_rd_seq.sv
// Restore-block read-out sequencer: walks the captured words in restore order,
// holds the current word while the consumer stalls, and pulses end_rd when done.
module mfa_cfg_rd_seq
  import mfa_cfg_gen_mc_pkg::*;
#(
  parameter int WIDTH_DATA = FTK_WIDTH,
  parameter int NUM_CFG    = 3,
  parameter int NUM_SHARED = 4
) (
  input  logic                                 clock,
  input  logic                                 reset,
  input  logic                                 str_rd,
  input  logic                                 nack,
  input  logic [WIDTH_DATA-1:0]                attr_rcfg,
  input  logic [WIDTH_DATA-1:0]                rcfg,
  input  logic [NUM_CFG-1:0][WIDTH_DATA-1:0]   cfg,
  input  logic [WIDTH_DATA-1:0]                attr_data,
  input  logic [NUM_SHARED-1:0][WIDTH_DATA-1:0] shared,
  input  logic                                 share_en,
  input  logic [$clog2(NUM_SHARED+1)-1:0]      scnt,
  output FTk_t                                 ftk,
  output logic                                 end_rd
);

  logic                    active;
  logic [MFA_RD_CNT_W-1:0] idx;
  logic [MFA_RD_CNT_W-1:0] n_lat;
  logic [MFA_RD_CNT_W-1:0] n_total;
  logic [WIDTH_DATA-1:0]   word;
  logic                    unused_msb;

  // The attribute MSB is always replayed as 0, so the stored bit is never read.
  assign unused_msb = attr_rcfg[WIDTH_DATA-1];

  assign n_total = MFA_RD_CNT_W'(NUM_CFG + 3) + (share_en ? MFA_RD_CNT_W'(scnt) : '0);

  always_ff @(posedge clock) begin
    if (!reset) begin
      active <= 1'b0;
      idx    <= '0;
      n_lat  <= '0;
      end_rd <= 1'b0;
    end else begin
      end_rd <= 1'b0;
      if (!active) begin
        if (str_rd) begin
          active <= 1'b1;
          idx    <= '0;
          n_lat  <= n_total;
        end
      end else if (!nack) begin
        if (idx == n_lat - 1'b1) begin
          active <= 1'b0;
          idx    <= '0;
          end_rd <= 1'b1;
        end else begin
          idx <= idx + 1'b1;
        end
      end
    end
  end

  // NOTE: every always_comb output gets a default first so no path can leave it
  // unassigned and infer a latch.
  always_comb begin
    word = '0;
    if (idx == '0) word = {1'b0, attr_rcfg[WIDTH_DATA-2:0]};
    if (idx == MFA_RD_CNT_W'(1)) word = rcfg;
    for (int k = 0; k < NUM_CFG; k++)
      if (idx == MFA_RD_CNT_W'(k + 2)) word = cfg[k];
    if (idx == MFA_RD_CNT_W'(NUM_CFG + 2)) word = attr_data;
    for (int k = 0; k < NUM_SHARED; k++)
      if (idx == MFA_RD_CNT_W'(k + NUM_CFG + 3)) word = shared[k];
  end

  always_comb begin
    ftk   = '0;
    ftk.v = active;
    ftk.d = word;
  end

endmodule

// File: rtl/mfa_cfg_gen_mc.sv
// MFA configuration generator: snoops the R-Config/config/attribute/shared words off the
// forward-token path and replays them as one restore block under downstream backpressure.
module mfa_cfg_gen_mc
  import mfa_cfg_gen_mc_pkg::*;
#(
  parameter int WIDTH_DATA   = FTK_WIDTH,
  parameter int WIDTH_LENGTH = 10,
  parameter int NUM_CFG      = 3,
  parameter int NUM_SHARED   = 4
) (
  input  logic                              clock,
  input  logic                              reset,
  input  logic                              I_Snoop_AttribRCfg,
  input  logic                              I_Snoop_AttribData,
  input  logic                              I_Str_Snoop,
  input  logic                              I_Set_SData,
  input  FTk_t                              I_FTk,
  input  logic                              I_Str_Rd,
  input  logic                              I_Nack,
  input  logic                              I_End_Store,
  input  logic                              I_End_Load,
  output FTk_t                              O_FTk,
  output logic                              O_End_Snoop,
  output logic                              O_End_Rd,
  output logic                              O_Busy,
  output logic [$clog2(NUM_SHARED+1)-1:0]   O_SCnt,
  output logic                              O_SOvf,
  output logic [WIDTH_LENGTH+1:0]           O_LengthData,
  output logic [WIDTH_DATA-1:0]             O_LengthConfig,
  output logic                              is_SharedAttrib,
  output logic                              is_NonZero,
  output logic                              is_Dense
);

  localparam int SCNT_W = $clog2(NUM_SHARED + 1);
  localparam int CIDX_W = $clog2(NUM_CFG + 1);

  logic                                  tok_v_q;
  logic [WIDTH_DATA-1:0]                 tok_d_q;
  logic                                  str_snoop_q;
  logic                                  attrib_rcfg_q;
  logic                                  set_sdata_q;
  logic                                  unused_ftk;

  fsm_cfg_gen_mc                         state;
  fsm_cfg_gen_mc                         state_nx;
  logic [CIDX_W-1:0]                     cfg_idx;
  logic                                  cfg_last;
  logic                                  cap_r;
  logic                                  cap_cfg;
  logic                                  to_idle;
  logic                                  end_snoop;

  logic [WIDTH_DATA-1:0]                 attr_rcfg;
  logic [WIDTH_DATA-1:0]                 rcfg;
  logic [WIDTH_DATA-1:0]                 attr_data;
  logic [NUM_CFG-1:0][WIDTH_DATA-1:0]    cfg;
  logic [NUM_SHARED-1:0][WIDTH_DATA-1:0] shared_q;
  attrib_flags_t                         flags;

  assign unused_ftk = ^{I_FTk.a, I_FTk.r, I_FTk.c, I_FTk.i};

  // NOTE: sequential state is always written with non-blocking assignments so every
  // flop samples pre-edge values regardless of block ordering.
  always_ff @(posedge clock) begin
    if (!reset) begin
      tok_v_q       <= 1'b0;
      tok_d_q       <= '0;
      str_snoop_q   <= 1'b0;
      attrib_rcfg_q <= 1'b0;
      set_sdata_q   <= 1'b0;
    end else begin
      tok_v_q       <= I_FTk.v;
      tok_d_q       <= I_FTk.d;
      str_snoop_q   <= I_Str_Snoop;
      attrib_rcfg_q <= I_Snoop_AttribRCfg;
      set_sdata_q   <= I_Set_SData;
    end
  end

  always_ff @(posedge clock) begin
    if (!reset) state <= IDLE;
    else        state <= state_nx;
  end

  assign cfg_last = (cfg_idx == CIDX_W'(NUM_CFG - 1));

  always_comb begin
    state_nx = state;
    unique case (state)
      IDLE:    if (str_snoop_q) state_nx = GET_R;
      GET_R:   if (tok_v_q) state_nx = GET_CFG;
      GET_CFG: if (tok_v_q && cfg_last) state_nx = WAIT;
      WAIT: begin
        if (!is_SharedAttrib) state_nx = IDLE;
        else if (I_Str_Rd)    state_nx = READ_S;
      end
      READ_S: begin
        if (!is_SharedAttrib) state_nx = IDLE;
        else if (I_End_Store) state_nx = READ_L;
      end
      READ_L:  if (I_End_Load) state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  always_comb begin
    cap_r   = (state == GET_R) && tok_v_q;
    cap_cfg = (state == GET_CFG) && tok_v_q;
    to_idle = (state != IDLE) && (state_nx == IDLE);
    O_Busy  = (state != IDLE);
  end

  // NOTE: the word registers are a handful of flops rather than a RAM, so they are
  // reset along with everything else; a real memory would be left unreset.
  always_ff @(posedge clock) begin
    if (!reset) begin
      cfg_idx   <= '0;
      end_snoop <= 1'b0;
      attr_rcfg <= '0;
      rcfg      <= '0;
      attr_data <= '0;
      cfg       <= '0;
      shared_q  <= '0;
      O_SCnt    <= '0;
      O_SOvf    <= 1'b0;
    end else begin
      end_snoop <= cap_cfg && cfg_last;
      if (attrib_rcfg_q)
        attr_rcfg <= tok_d_q & ~(WIDTH_DATA'(1) << POSIT_ATTRIB_SHARED);
      if (I_Snoop_AttribData) attr_data <= tok_d_q;
      if (cap_r) begin
        rcfg    <= tok_d_q;
        cfg_idx <= '0;
      end
      if (cap_cfg) begin
        for (int k = 0; k < NUM_CFG; k++)
          if (cfg_idx == CIDX_W'(k)) cfg[k] <= tok_d_q;
        cfg_idx <= cfg_last ? '0 : cfg_idx + 1'b1;
      end
      // Shared words accumulate until the FSM falls back to IDLE.
      if (to_idle) begin
        O_SCnt <= '0;
        O_SOvf <= 1'b0;
      end else if (set_sdata_q) begin
        if (O_SCnt == SCNT_W'(NUM_SHARED)) begin
          O_SOvf <= 1'b1;
        end else begin
          for (int k = 0; k < NUM_SHARED; k++)
            if (O_SCnt == SCNT_W'(k)) shared_q[k] <= tok_d_q;
          O_SCnt <= O_SCnt + 1'b1;
        end
      end
    end
  end

  assign O_End_Snoop    = end_snoop;
  assign O_LengthConfig = cfg[0];
  assign O_LengthData   = {2'b00, attr_data[POSIT_ATTRIB_LENGTH_LSB +: WIDTH_LENGTH]};

  assign flags           = attribute_dec(attr_data);
  assign is_SharedAttrib = flags.shared;
  assign is_NonZero      = flags.non_zero;
  assign is_Dense        = flags.dense;

  mfa_cfg_rd_seq #(
    .WIDTH_DATA (WIDTH_DATA),
    .NUM_CFG    (NUM_CFG),
    .NUM_SHARED (NUM_SHARED)
  ) u_rd_seq (
    .clock     (clock),
    .reset     (reset),
    .str_rd    (I_Str_Rd),
    .nack      (I_Nack),
    .attr_rcfg (attr_rcfg),
    .rcfg      (rcfg),
    .cfg       (cfg),
    .attr_data (attr_data),
    .shared    (shared_q),
    .share_en  (is_SharedAttrib),
    .scnt      (O_SCnt),
    .ftk       (O_FTk),
    .end_rd    (O_End_Rd)
  );

endmodule

// File: tb/tb_mfa_cfg_gen_mc.sv
// Directed/randomised bench for mfa_cfg_gen_mc; expected restore blocks come from a
// word-list model built from the snooped values.
module tb_mfa_cfg_gen_mc;
  import mfa_cfg_gen_mc_pkg::*;

  localparam int NUM_CFG    = 3;
  localparam int NUM_SHARED = 4;
  localparam int WL         = 10;

  logic        clock = 1'b0;
  logic        reset;
  logic        I_Snoop_AttribRCfg, I_Snoop_AttribData, I_Str_Snoop, I_Set_SData;
  FTk_t        I_FTk;
  logic        I_Str_Rd, I_Nack, I_End_Store, I_End_Load;
  FTk_t        O_FTk;
  logic        O_End_Snoop, O_End_Rd, O_Busy, O_SOvf;
  logic [2:0]  O_SCnt;
  logic [WL+1:0] O_LengthData;
  logic [31:0] O_LengthConfig;
  logic        is_SharedAttrib, is_NonZero, is_Dense;

  mfa_cfg_gen_mc #(
    .WIDTH_DATA(32), .WIDTH_LENGTH(WL), .NUM_CFG(NUM_CFG), .NUM_SHARED(NUM_SHARED)
  ) dut (
    .clock(clock), .reset(reset),
    .I_Snoop_AttribRCfg(I_Snoop_AttribRCfg), .I_Snoop_AttribData(I_Snoop_AttribData),
    .I_Str_Snoop(I_Str_Snoop), .I_Set_SData(I_Set_SData), .I_FTk(I_FTk),
    .I_Str_Rd(I_Str_Rd), .I_Nack(I_Nack), .I_End_Store(I_End_Store), .I_End_Load(I_End_Load),
    .O_FTk(O_FTk), .O_End_Snoop(O_End_Snoop), .O_End_Rd(O_End_Rd), .O_Busy(O_Busy),
    .O_SCnt(O_SCnt), .O_SOvf(O_SOvf), .O_LengthData(O_LengthData),
    .O_LengthConfig(O_LengthConfig), .is_SharedAttrib(is_SharedAttrib),
    .is_NonZero(is_NonZero), .is_Dense(is_Dense)
  );

  always #5 clock = ~clock;

  int errors = 0;
  int checks = 0;

  logic [31:0] m_attr_rcfg, m_rcfg, m_attr_data;
  logic [31:0] m_cfg [NUM_CFG];
  logic [31:0] m_shared[$];
  logic [31:0] exp_words[$];

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic drive_tok(input logic v, input logic [31:0] d);
    I_FTk   = '0;
    I_FTk.v = v;
    I_FTk.d = d;
  endtask

  function automatic int held_shared();
    return (m_shared.size() > NUM_SHARED) ? NUM_SHARED : m_shared.size();
  endfunction

  // Restore-block order: masked R-Config attribute, R-Config, cfg words, data attribute,
  // then the held shared words when the data attribute carries the share flag.
  function automatic void build_exp();
    logic [31:0] a;
    exp_words.delete();
    a = m_attr_rcfg;
    a[31] = 1'b0;
    a[27] = 1'b0;
    exp_words.push_back(a);
    exp_words.push_back(m_rcfg);
    for (int k = 0; k < NUM_CFG; k++) exp_words.push_back(m_cfg[k]);
    exp_words.push_back(m_attr_data);
    if (m_attr_data[27])
      for (int k = 0; k < held_shared(); k++) exp_words.push_back(m_shared[k]);
  endfunction

  task automatic load_attr(input logic [31:0] ra, input logic [31:0] da);
    m_attr_rcfg = ra;
    m_attr_data = da;
    drive_tok(1'b1, ra);
    I_Snoop_AttribRCfg = 1'b1;
    tick();
    I_Snoop_AttribRCfg = 1'b0;
    drive_tok(1'b1, da);
    tick();
    I_Snoop_AttribData = 1'b1;
    tick();
    I_Snoop_AttribData = 1'b0;
    drive_tok(1'b0, '0);
    check("dec_length", 64'(O_LengthData), 64'(da[WL-1:0]));
    check("dec_shared", 64'(is_SharedAttrib), 64'(da[27]));
    check("dec_nonzero", 64'(is_NonZero), 64'(da[POSIT_ATTRIB_NONZERO]));
    check("dec_dense", 64'(is_Dense), 64'(da[POSIT_ATTRIB_DENSE]));
  endtask

  task automatic load_shared(input int n);
    logic [31:0] w;
    for (int k = 0; k < n; k++) begin
      w = $urandom;
      m_shared.push_back(w);
      drive_tok(1'b1, w);
      I_Set_SData = 1'b1;
      tick();
    end
    I_Set_SData = 1'b0;
    drive_tok(1'b0, '0);
    tick();
    tick();
    check("scnt", 64'(O_SCnt), 64'(held_shared()));
    check("sovf", 64'(O_SOvf), 64'(m_shared.size() > NUM_SHARED));
  endtask

  task automatic snoop(input int bubble_at);
    I_Str_Snoop = 1'b1;
    tick();
    I_Str_Snoop = 1'b0;
    drive_tok(1'b1, m_rcfg);
    tick();
    for (int k = 0; k < NUM_CFG; k++) begin
      if (k == bubble_at) begin
        drive_tok(1'b0, 32'hDEAD_BEEF);
        tick();
      end
      drive_tok(1'b1, m_cfg[k]);
      tick();
    end
    check("end_snoop_early", 64'(O_End_Snoop), 64'(0));
    drive_tok(1'b0, '0);
    tick();
    check("end_snoop_pulse", 64'(O_End_Snoop), 64'(1));
    check("length_config", 64'(O_LengthConfig), 64'(m_cfg[0]));
    tick();
    check("end_snoop_clear", 64'(O_End_Snoop), 64'(0));
    check("busy_after_snoop", 64'(O_Busy), 64'(m_attr_data[27]));
  endtask

  task automatic read_out(input int nack_at, input int nack_len, input int dup_at);
    FTk_t e;
    build_exp();
    I_Str_Rd = 1'b1;
    tick();
    I_Str_Rd = 1'b0;
    for (int k = 0; k < exp_words.size(); k++) begin
      e   = '0;
      e.v = 1'b1;
      e.d = exp_words[k];
      if (k == nack_at) begin
        for (int j = 0; j < nack_len; j++) begin
          I_Nack = 1'b1;
          check($sformatf("rd_hold%0d_%0d", k, j), 64'(O_FTk), 64'(e));
          tick();
        end
      end
      I_Nack = 1'b0;
      if (k == dup_at) I_Str_Rd = 1'b1;
      check($sformatf("rd_word%0d", k), 64'(O_FTk), 64'(e));
      check($sformatf("rd_noend%0d", k), 64'(O_End_Rd), 64'(0));
      tick();
      I_Str_Rd = 1'b0;
    end
    check("end_rd_pulse", 64'(O_End_Rd), 64'(1));
    check("rd_valid_low", 64'(O_FTk.v), 64'(0));
    tick();
    check("end_rd_clear", 64'(O_End_Rd), 64'(0));
  endtask

  task automatic finish_restore();
    I_End_Store = 1'b1;
    tick();
    I_End_Store = 1'b0;
    check("busy_read_l", 64'(O_Busy), 64'(1));
    I_End_Load = 1'b1;
    tick();
    I_End_Load = 1'b0;
    m_shared.delete();
    check("busy_idle", 64'(O_Busy), 64'(0));
    check("scnt_cleared", 64'(O_SCnt), 64'(0));
    check("sovf_cleared", 64'(O_SOvf), 64'(0));
  endtask

  task automatic apply_reset();
    reset = 1'b0;
    tick();
    reset = 1'b1;
    m_attr_rcfg = '0;
    m_attr_data = '0;
    m_rcfg      = '0;
    for (int k = 0; k < NUM_CFG; k++) m_cfg[k] = '0;
    m_shared.delete();
  endtask

  task automatic random_cfg();
    m_rcfg = $urandom;
    for (int k = 0; k < NUM_CFG; k++) m_cfg[k] = $urandom;
  endtask

  function automatic logic [31:0] rand_attr(input logic share);
    logic [31:0] a;
    a = $urandom;
    a[27] = share;
    return a;
  endfunction

  initial begin
    reset = 1'b0;
    I_Snoop_AttribRCfg = 1'b0;
    I_Snoop_AttribData = 1'b0;
    I_Str_Snoop = 1'b0;
    I_Set_SData = 1'b0;
    I_Str_Rd = 1'b0;
    I_Nack = 1'b0;
    I_End_Store = 1'b0;
    I_End_Load = 1'b0;
    drive_tok(1'b0, '0);
    tick();
    tick();
    reset = 1'b1;

    // Reset state
    check("rst_ftk", 64'(O_FTk), 64'(0));
    check("rst_busy", 64'(O_Busy), 64'(0));
    check("rst_scnt", 64'(O_SCnt), 64'(0));
    check("rst_sovf", 64'(O_SOvf), 64'(0));
    check("rst_len", 64'({O_LengthData, O_LengthConfig}), 64'(0));
    check("rst_flags", 64'({is_SharedAttrib, is_NonZero, is_Dense}), 64'(0));
    check("rst_pulses", 64'({O_End_Snoop, O_End_Rd}), 64'(0));

    // Fixed config words, no sharing; a redundant Str_Rd mid-block is ignored
    load_attr(32'hFFFF_FFFF, rand_attr(1'b0));
    m_rcfg = 32'h10;
    m_cfg[0] = 32'h20;
    m_cfg[1] = 32'h4;
    m_cfg[2] = 32'h1000;
    snoop(-1);
    read_out(-1, 0, 2);
    check("idle_after_a", 64'(O_Busy), 64'(0));

    // Sharing with two words, a v=0 bubble in the config stream
    load_attr(rand_attr(1'b1), rand_attr(1'b1));
    m_shared.push_back(32'hAA);
    m_shared.push_back(32'hBB);
    drive_tok(1'b1, 32'hAA); I_Set_SData = 1'b1; tick();
    drive_tok(1'b1, 32'hBB); tick();
    I_Set_SData = 1'b0; drive_tok(1'b0, '0); tick(); tick();
    check("scnt_two", 64'(O_SCnt), 64'(2));
    random_cfg();
    snoop(1);
    read_out(-1, 0, -1);
    check("busy_read_s", 64'(O_Busy), 64'(1));
    finish_restore();

    // Shared overflow plus a 3-cycle stall on word 3
    load_attr(rand_attr(1'b0), rand_attr(1'b1));
    load_shared(5);
    random_cfg();
    snoop(-1);
    read_out(3, 3, -1);
    check("sovf_sticky", 64'(O_SOvf), 64'(1));
    finish_restore();

    // Reset during GET_CFG aborts silently
    load_attr(rand_attr(1'b1), rand_attr(1'b0));
    random_cfg();
    I_Str_Snoop = 1'b1; tick(); I_Str_Snoop = 1'b0;
    drive_tok(1'b1, m_rcfg); tick();
    drive_tok(1'b1, m_cfg[0]); tick();
    drive_tok(1'b1, m_cfg[1]); tick();
    apply_reset();
    check("rst_cfg_busy", 64'(O_Busy), 64'(0));
    check("rst_cfg_valid", 64'(O_FTk.v), 64'(0));
    for (int j = 0; j < 4; j++) begin
      drive_tok(1'b1, $urandom);
      check($sformatf("rst_cfg_noend%0d", j), 64'({O_End_Snoop, O_Busy}), 64'(0));
      tick();
    end
    drive_tok(1'b0, '0);

    // Reset during read word 4 aborts silently
    load_attr(rand_attr(1'b0), rand_attr(1'b0));
    random_cfg();
    snoop(-1);
    I_Str_Rd = 1'b1; tick(); I_Str_Rd = 1'b0;
    for (int k = 0; k < 4; k++) tick();
    apply_reset();
    check("rst_rd_valid", 64'(O_FTk.v), 64'(0));
    check("rst_rd_busy", 64'(O_Busy), 64'(0));
    check("rst_rd_noend0", 64'(O_End_Rd), 64'(0));
    tick();
    check("rst_rd_noend1", 64'(O_End_Rd), 64'(0));

    // A fresh snoop and read after the aborts
    load_attr(rand_attr(1'b0), rand_attr(1'b0));
    random_cfg();
    snoop(0);
    read_out(0, 2, -1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/mfa_cfg_gen_mc.md
Name: mfa_cfg_gen_mc

Overview:
- Parametrised successor of the MFA configuration generator used by the Index-Compression extension.
- Snoops the R-Config attribute word, the R-Config word, NUM_CFG configuration words, the data-block attribute word and up to NUM_SHARED shared data words.
- Replays them as one restore block, with backpressure, so the compressed block can be restored.
- Sits beside the MFA sequencer, between the snooped forward-token path and the restore store/load path.

Parameters:
WIDTH_DATA, 32, data word width.
WIDTH_LENGTH, 10, length-field width in the attribute and config words.
NUM_CFG, 3, number of configuration words after the R-Config word (length, stride, base, ...); range 1..8.
NUM_SHARED, 4, maximum number of shared (MFA) data words held; range 1..8.

Ports:
clock  in  1  system clock
reset  in  1  synchronous, active-low reset
I_Snoop_AttribRCfg  in  1  current I_FTk is the R-Config attribute word
I_Snoop_AttribData  in  1  current I_FTk is the data-block attribute word
I_Str_Snoop  in  1  start snooping the config sequence
I_Set_SData  in  1  current I_FTk is a shared data word
I_FTk  in  FTk_t  snooped forward token
I_Str_Rd  in  1  start read-out
I_Nack  in  1  downstream stall; hold O_FTk
I_End_Store  in  1  restore store finished
I_End_Load  in  1  restore load finished
O_FTk  out  FTk_t  read-out token
O_End_Snoop  out  1  pulse: last config word captured
O_End_Rd  out  1  pulse: read-out complete
O_Busy  out  1  FSM not IDLE
O_SCnt  out  $clog2(NUM_SHARED+1)  shared words held
O_SOvf  out  1  sticky: shared capture overflow
O_LengthData  out  WIDTH_LENGTH+2  length field of the data attribute word
O_LengthConfig  out  WIDTH_DATA  config word 0
is_SharedAttrib  out  1  share flag of the data attribute word
is_NonZero  out  1  NonZero flag of the data attribute word
is_Dense  out  1  Dense flag of the data attribute word

Behaviour:
- Reset (reset==0 at posedge):
  - All registers, counters and outputs go to 0.
  - FSM goes to IDLE; O_FTk.v=0.
  - Reset mid-snoop or mid-read aborts the operation with no O_End_* pulse.
- Input retiming:
  - I_FTk, I_Str_Snoop, I_Snoop_AttribRCfg and I_Set_SData are registered once.
  - All captures use the registered copies, so capture latency is 1 cycle.
  - I_Snoop_AttribData captures the registered token directly, with no extra delay.
- R-Config attribute capture:
  - The share bit at POSIT_ATTRIB_SHARED is stored cleared.
  - On read-out, the MSB is also forced to 0.
- Snoop FSM transitions:
  - IDLE -> GET_R on registered Str_Snoop. Str_Snoop outside IDLE is ignored.
  - GET_R: on a valid token, capture the R-Config word, then go to GET_CFG with the cfg index at 0.
  - GET_CFG: on a valid token, capture into cfg[idx] and increment idx. At idx==NUM_CFG-1: pulse O_End_Snoop and go to WAIT.
  - Tokens with v=0 are skipped in every GET state.
  - WAIT: if is_SharedAttrib==0, go to IDLE. Else if I_Str_Rd, go to READ_S.
  - READ_S: if is_SharedAttrib drops, go to IDLE. Else on I_End_Store, go to READ_L.
  - READ_L: on I_End_Load, go to IDLE. Leaving to IDLE clears O_SCnt and O_SOvf.
- Shared capture:
  - Each registered Set_SData writes shared[O_SCnt] and increments O_SCnt.
  - At O_SCnt==NUM_SHARED the word is dropped and O_SOvf is set (sticky until IDLE).
  - Set_SData together with a GET capture: both happen.
- Read-out sequencer:
  - Starts on I_Str_Rd only when the sequencer is idle; I_Str_Rd during read-out is ignored.
  - Word order: R-Config attribute, R-Config word, cfg[0..NUM_CFG-1], data attribute, then shared[0..O_SCnt-1] only if is_SharedAttrib.
  - Total words: N = NUM_CFG + 3 + (is_SharedAttrib ? O_SCnt : 0).
  - The first word is on O_FTk the cycle after I_Str_Rd; O_FTk.v=1 while words are being sent.
  - O_FTk.a, .r and .c are 0; O_FTk.i is 0 when EXTEND is defined.
  - I_Nack=1 holds O_FTk and the index. The index advances only when v=1 and I_Nack=0.
  - O_End_Rd pulses one cycle after the last word is accepted; v=0 that same cycle.
  - N is latched at start; shared words captured afterwards are not sent.
- Decode:
  - is_* flags and O_LengthData are combinational from the held data attribute word, bits [WIDTH_LENGTH+POSIT_ATTRIB_LENGTH_LSB-1 : POSIT_ATTRIB_LENGTH_LSB].

Decomposition:
- pkg_extend_index gains:
  - fsm_cfg_gen_mc enum (IDLE, GET_R, GET_CFG, WAIT, READ_S, READ_L);
  - POSIT_ATTRIB_SHARED (= WIDTH_DATA-5);
  - MFA_RD_CNT_W.
- FTk_t and POSIT_ATTRIB_LENGTH_LSB come from pkg_en.
- Reuse AttributeDec for the flags.
- One natural sub-module, mfa_cfg_rd_seq:
  - contains the read index, N latch, mux, nack hold and End_Rd pulse;
  - takes its inputs from the word registers.

Test Plan:
- NUM_CFG=3, snoop the words 0x10, 0x20, 0x4, 0x1000, one per cycle, each with v=1 -> O_End_Snoop pulses 1 cycle after 0x1000 is registered; O_LengthConfig=0x20.
- Data attribute with share=0, I_Str_Rd -> 6 words on consecutive cycles; R-Config attribute with bit27 clear; O_End_Rd pulses at cycle 7; FSM returns to IDLE.
- share=1 and 2 shared words 0xAA, 0xBB -> 8 words ending 0xAA, 0xBB; O_SCnt=2; FSM goes WAIT->READ_S->READ_L->IDLE on I_End_Store then I_End_Load.
- 5 Set_SData pulses with NUM_SHARED=4 -> O_SCnt=4, O_SOvf=1, the 5th word is absent from read-out.
- I_Nack=1 for 3 cycles at word 3 -> word 3 held stable for 4 cycles; no word skipped or duplicated; O_End_Rd delayed by 3 cycles.
- reset=0 during GET_CFG and again during read word 4 -> O_FTk.v=0 and O_Busy=0 the next cycle; no O_End_Snoop or O_End_Rd pulse; a fresh snoop then succeeds.
